// File: rtl/arith_pkg.sv
// arith_pkg: width constants shared by the arithmetic unit's adder and subtractor
//   DEFAULT_WIDTH - default operand width
//   RESULT_WIDTH  - result width, one extra bit for carry/borrow
package arith_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam int RESULT_WIDTH  = DEFAULT_WIDTH + 1;
endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: one-bit ripple-borrow subtractor cell
//   a, b - minuend and subtrahend bits
//   bin  - borrow in from the next lower bit
//   d    - difference bit
//   bout - borrow out to the next higher bit
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/subtrator_8bits.sv
// subtrator_8bits: registered unsigned subtractor, S = {borrow, A - B}
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   A, B      - unsigned minuend and subtrahend
//   in_valid  - operands valid this cycle
//   S         - registered difference; S[WIDTH] is the borrow and the sign
//   out_valid - S holds a result captured on the last edge
module subtrator_8bits
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH:0]   S,
    output logic             out_valid
);
    logic [WIDTH:0]   bw;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   s_d, s_q;
    logic             v_d, v_q;

    assign bw[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor u_fs (
            .a   (A[i]),
            .b   (B[i]),
            .bin (bw[i]),
            .d   (d[i]),
            .bout(bw[i+1])
        );
    end

    // S keeps its last value while no new operands arrive
    always_comb begin
        s_d = in_valid ? {bw[WIDTH], d} : s_q;
        v_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
            v_q <= 1'b0;
        end else begin
            s_q <= s_d;
            v_q <= v_d;
        end
    end

    assign S         = s_q;
    assign out_valid = v_q;
endmodule

// File: tb/tb_subtrator_8bits.sv
// tb_subtrator_8bits: directed and random check of subtrator_8bits against an arithmetic model
module tb_subtrator_8bits;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       in_valid = 1'b0;
    logic [8:0] S;
    logic       out_valid;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] exp_s = '0;
    logic       exp_v = 1'b0;

    subtrator_8bits dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .in_valid (in_valid),
        .S        (S),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // apply one cycle of stimulus, advance the model, compare after the edge
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic v, input logic r);
        A = a;
        B = b;
        in_valid = v;
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            exp_s = '0;
            exp_v = 1'b0;
        end else if (v) begin
            exp_s = 9'(({1'b0, a} - {1'b0, b}) % 512);
            exp_v = 1'b1;
        end else begin
            exp_v = 1'b0;
        end
        check("S", S, exp_s);
        check("out_valid", {8'b0, out_valid}, {8'b0, exp_v});
        if (!r && v)
            check("sign", {8'b0, S[8]}, {8'b0, (a < b)});
    endtask

    logic [7:0] va [8] = '{8'd0, 8'd1, 8'd85, 8'd255, 8'd0, 8'd0, 8'd0, 8'd128};
    logic [7:0] vb [8] = '{8'd0, 8'd1, 8'd42, 8'd128, 8'd1, 8'd255, 8'd0, 8'd255};
    logic [8:0] vs [8] = '{9'h000, 9'h000, 9'h02B, 9'h07F, 9'h1FF, 9'h101, 9'h000, 9'h181};

    initial begin
        step(8'hFF, 8'h00, 1'b1, 1'b1);
        step(8'hFF, 8'h00, 1'b1, 1'b1);
        check("reset_S", S, 9'h000);
        for (int i = 0; i < 8; i++) begin
            step(va[i], vb[i], 1'b1, 1'b0);
            check("table", S, vs[i]);
        end
        step(8'h12, 8'h34, 1'b0, 1'b0);
        check("hold", S, 9'h181);
        step(8'h56, 8'h78, 1'b0, 1'b0);
        check("hold2", S, 9'h181);
        for (int i = 0; i < 10000; i++)
            step(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 63) == 0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
